// File: rtl/sram_like_slave_mem.sv
// SRAM-like bus responder backed by a word-organised on-chip memory.
// Fixed response latency, bounded outstanding requests, strictly in-order responses.
module sram_like_slave_mem #(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]        mem [DEPTH];
  logic [ADDR_W-1:0]  index;
  logic [3:0]         byte_mask;
  logic               accept;
  logic [CNT_W-1:0]   cnt_q;
  logic [LATENCY-1:0] valid_q;
  logic [31:0]        data_q [LATENCY];
  logic               unused_addr_hi;

  // Address bits above the word index alias onto the same memory.
  assign index          = addr[ADDR_W+1:2];
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  always_comb begin
    byte_mask = 4'b1111;
    case (size)
      2'd0:    byte_mask = 4'b0001 << addr[1:0];
      2'd1:    byte_mask = addr[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  end

  // A slot being retired by data_ok this cycle can be handed straight to a new request.
  assign addr_ok = req & ~stall & ~reset & ((cnt_q < CNT_MAX) | data_ok);
  assign accept  = req & addr_ok;

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_mask[b]) mem[index][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Write responses carry zero data, so rdata is simply the last stage register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= accept;
      data_q[0]  <= (accept && !wr) ? mem[index] : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign data_ok = valid_q[LATENCY-1];
  assign rdata   = data_q[LATENCY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept && !data_ok) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (!accept && data_ok) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule
